// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// default multiply latency and a sign-fixup helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    localparam int MUL_LAT_DEFAULT = 3;
    localparam int DIV_ITERS       = 32;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_div.sv
// 32-iteration restoring divider with sign fixup; used by mdu when MDU_DIV_EN
// is defined. Divide-by-zero is resolved here rather than by the iterations.
module mdu_div
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        last_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic [31:0] rem_q, rem_d, quot_q, quot_d, dsr_q, dsr_d, raw_q, raw_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        negq_q, negq_d, negr_q, negr_d, zero_q, zero_d;
    logic [32:0] shift_s, diff_s;
    logic        fits_s;

    // Iteration datapath: remainder always stays below the divisor, so a
    // borrow out of bit 32 means the trial subtraction failed.
    always_comb begin
        shift_s = {rem_q, quot_q[31]};
        diff_s  = shift_s - {1'b0, dsr_q};
        fits_s  = ~diff_s[32];
        rem_d   = rem_q;
        quot_d  = quot_q;
        dsr_d   = dsr_q;
        raw_d   = raw_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        if (load_i) begin
            rem_d  = 32'd0;
            quot_d = cond_neg(dividend_i, signed_i & dividend_i[31]);
            dsr_d  = cond_neg(divisor_i, signed_i & divisor_i[31]);
            raw_d  = dividend_i;
            cnt_d  = 5'd0;
            negq_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
            negr_d = signed_i & dividend_i[31];
            zero_d = (divisor_i == 32'd0);
        end else if (step_i) begin
            rem_d  = fits_s ? diff_s[31:0] : shift_s[31:0];
            quot_d = {quot_q[30:0], fits_s};
            cnt_d  = cnt_q + 5'd1;
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Divider state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= 32'd0;
            quot_q <= 32'd0;
            dsr_q  <= 32'd0;
            raw_q  <= 32'd0;
            cnt_q  <= 5'd0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dsr_q  <= dsr_d;
            raw_q  <= raw_d;
            cnt_q  <= cnt_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            zero_q <= zero_d;
        end
    end

    assign last_o = (cnt_q == 5'(DIV_ITERS - 1));
    assign quot_o = zero_q ? 32'hFFFF_FFFF : cond_neg(quot_q, negq_q);
    assign rem_o  = zero_q ? raw_q : cond_neg(rem_q, negr_q);

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. Define MDU_DIV_EN to build the
// divide path; without it DIV/DIVU are ignored like reserved ops.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, opa_q, opa_d, opb_q, opb_d;
    logic        sgn_q, sgn_d, done_q, done_d;
    logic [2:0]  lat_q, lat_d;
    logic [63:0] ext_a_s, ext_b_s, prod_s;

`ifdef MDU_DIV_EN
    logic        div_load_s, div_step_s, div_last_s;
    logic [31:0] div_quot_s, div_rem_s;

    mdu_div u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (div_load_s),
        .step_i     (div_step_s),
        .signed_i   (op == OP_DIV),
        .dividend_i (rs_data),
        .divisor_i  (rt_data),
        .last_o     (div_last_s),
        .quot_o     (div_quot_s),
        .rem_o      (div_rem_s)
    );
`endif

    // Truncated 64x64 product of extended operands gives both signed and unsigned results
    always_comb begin
        ext_a_s = sgn_q ? {{32{opa_q[31]}}, opa_q} : {32'd0, opa_q};
        ext_b_s = sgn_q ? {{32{opb_q[31]}}, opb_q} : {32'd0, opb_q};
        prod_s  = ext_a_s * ext_b_s;
    end

    // Next-state and HI/LO update logic
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sgn_d   = sgn_q;
        lat_d   = lat_q;
        done_d  = 1'b0;
`ifdef MDU_DIV_EN
        div_load_s = 1'b0;
        div_step_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            opa_d   = rs_data;
                            opb_d   = rt_data;
                            sgn_d   = (op == OP_MULT);
                            lat_d   = 3'(MUL_LAT - 1);
                            state_d = ST_MUL;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
`ifdef MDU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            div_load_s = 1'b1;
                            state_d    = ST_DIV;
                        end
`endif
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (lat_q == 3'd0) begin
                    hi_d    = prod_s[63:32];
                    lo_d    = prod_s[31:0];
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
`ifdef MDU_DIV_EN
            ST_DIV: begin
                div_step_s = 1'b1;
                if (div_last_s) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_FIX: begin
                hi_d    = div_rem_s;
                lo_d    = div_quot_s;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and architectural register update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            sgn_q   <= 1'b0;
            lat_q   <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
            lat_q   <= lat_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO and completion cycle are queued at
// issue time and compared whenever done pulses.
module tb_mdu;

    localparam int LAT = 3;
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data, hi, lo;
    logic        busy, done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu #(.MUL_LAT(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        longint          sx, sy, sp;
        longint unsigned ux, uy, up;
        int              sa, sbv;
        e.cyc = 0;
        e.hi  = 32'd0;
        e.lo  = 32'd0;
        case (o)
            3'b000: begin
                sx = longint'($signed(a));
                sy = longint'($signed(b));
                sp = sx * sy;
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            3'b001: begin
                ux = a;
                uy = b;
                up = ux * uy;
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else if (o == 3'b011) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'd0;
                end else begin
                    sa   = $signed(a);
                    sbv  = $signed(b);
                    e.lo = sa / sbv;
                    e.hi = sa % sbv;
                end
            end
        endcase
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding result
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("hi", {32'd0, hi}, {32'd0, e.hi});
                check("lo", {32'd0, lo}, {32'd0, e.lo});
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_at_done", {63'd0, busy}, 64'd0);
                m_hi = e.hi;
                m_lo = e.lo;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start cycle; push the expectation only when the op should complete
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit completes);
        exp_t e;
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        if (completes) begin
            e = model(o, a, b);
            e.cyc = cyc + 1 + ((o[1] == 1'b1) ? DIV_LAT : LAT);
            sb.push_back(e);
        end
        tick();
        start   = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        rst = 1'b1; start = 1'b0; op = 3'b000; rs_data = 32'd0; rt_data = 32'd0;
        repeat (3) tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        tick();

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("mul_busy", {63'd0, busy}, 64'd1);
        // a start while busy must be ignored: no extra result appears
        issue(3'b001, 32'h1234_5678, 32'h0000_0002, 1'b0);
        wait_idle();
        issue(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            ro = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b001;
            ra = $urandom;
            rb = (i == 0) ? 32'h8000_0000 : $urandom;
            issue(ro, ra, rb, 1'b1);
            wait_idle();
        end
        tick();
        check("hold_hi", {32'd0, hi}, {32'd0, m_hi});
        check("hold_lo", {32'd0, lo}, {32'd0, m_lo});

        issue(3'b100, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi", {32'd0, hi}, 64'h1234_5678);
        issue(3'b101, 32'hCAFE_F00D, 32'd0, 1'b0);
        check("mtlo", {32'd0, lo}, 64'hCAFE_F00D);
        check("mthi_kept", {32'd0, hi}, 64'h1234_5678);
        check("mt_busy", {63'd0, busy}, 64'd0);
        m_hi = 32'h1234_5678;
        m_lo = 32'hCAFE_F00D;

        for (int r = 6; r < 8; r++) begin
            issue(3'(r), 32'hDEAD_BEEF, 32'h5, 1'b0);
            check("rsv_busy", {63'd0, busy}, 64'd0);
            check("rsv_hi", {32'd0, hi}, {32'd0, m_hi});
            check("rsv_lo", {32'd0, lo}, {32'd0, m_lo});
        end

`ifdef MDU_DIV_EN
        issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        issue(3'b011, 32'd100, 32'd0, 1'b1);
        wait_idle();
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        issue(3'b010, 32'd7, 32'hFFFF_FFFE, 1'b1);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            ro = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b011;
            issue(ro, $urandom, 32'($urandom_range(1, 1000)), 1'b1);
            wait_idle();
        end
        issue(3'b010, 32'd1000, 32'd3, 1'b1);
        repeat (8) tick();
        issue(3'b100, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check("busy_ign_hi", {32'd0, hi}, {32'd0, m_hi});
        check("div_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        repeat (40) tick();
`else
        issue(3'b010, 32'd77, 32'd7, 1'b0);
        check("nodiv_busy", {63'd0, busy}, 64'd0);
        check("nodiv_hi", {32'd0, hi}, {32'd0, m_hi});
        check("nodiv_lo", {32'd0, lo}, {32'd0, m_lo});
        issue(3'b011, 32'd77, 32'd0, 1'b0);
        check("nodivu_busy", {63'd0, busy}, 64'd0);
        repeat (40) tick();
`endif

        // reset wins over a simultaneous start
        rst = 1'b1;
        issue(3'b000, 32'd5, 32'd6, 1'b0);
        rst = 1'b0;
        check("rst_over_start", {63'd0, busy}, 64'd0);
        repeat (10) tick();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
